// File: rtl/ahb_burst_master.sv
// rtl/ahb_burst_master.sv - AHB-Lite master issuing SINGLE/INCR bursts of 64-bit beats
//
// Turns one command (write/read, start address, beats-1) into an AHB-Lite
// SINGLE or INCR burst. Address and data phases are pipelined. Wait states
// hold the bus. A two-cycle ERROR response drops the rest of the burst.
//
// Ports:
//   HCLK, HRESET           bus clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_ready is high only in IDLE
//   cmd_write              1 = write burst, 0 = read burst
//   cmd_addr               8-byte aligned start address, burst within 1 KB
//   cmd_len                beats minus one
//   wr_data, wr_pop        write word source; wr_pop marks each word taken
//   rd_valid, rd_data      one pulse per completed read beat with its data
//   done, err              end-of-burst pulses (clean / ERROR terminated)
//   HADDR..HWDATA          AHB-Lite master outputs
//   HREADY, HRESP, HRDATA  AHB-Lite slave responses
module ahb_burst_master #(
    parameter int LEN_W  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_pop,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic              HMASTLOCK,
    output logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    input  logic [DATA_W-1:0] HRDATA
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_LAST,
        ST_ERR
    } state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR   = 3'b001;

    state_t            state, state_d;
    // Address phases still to issue after the one currently on the bus.
    logic [LEN_W-1:0]  addr_left, addr_left_d;
    // A data phase is in flight (false during the very first NONSEQ cycle).
    logic              dph_valid, dph_valid_d;

    logic [1:0]        htrans_d;
    logic [ADDR_W-1:0] haddr_d;
    logic              hwrite_d;
    logic [2:0]        hburst_d;
    logic [DATA_W-1:0] hwdata_d;
    logic [DATA_W-1:0] rd_data_d;
    logic              wr_pop_d;
    logic              rd_valid_d;
    logic              done_d;
    logic              err_d;
    logic              cmd_ready_d;

    // Fixed transfer attributes: 64-bit beats, data/privileged, never locked.
    assign HSIZE     = 3'b011;
    assign HPROT     = 4'h3;
    assign HMASTLOCK = 1'b0;

    always_comb begin
        state_d     = state;
        addr_left_d = addr_left;
        dph_valid_d = dph_valid;
        htrans_d    = HTRANS;
        haddr_d     = HADDR;
        hwrite_d    = HWRITE;
        hburst_d    = HBURST;
        hwdata_d    = HWDATA;
        rd_data_d   = rd_data;
        wr_pop_d    = 1'b0;
        rd_valid_d  = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        cmd_ready_d = 1'b0;

        unique case (state)
            ST_IDLE: begin
                // cmd_ready is registered, so it rises one cycle after the
                // burst that just finished returned the FSM here.
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    cmd_ready_d = 1'b0;
                    htrans_d    = TR_NONSEQ;
                    haddr_d     = cmd_addr;
                    hwrite_d    = cmd_write;
                    hburst_d    = (cmd_len == '0) ? BURST_SINGLE : BURST_INCR;
                    addr_left_d = cmd_len;
                    dph_valid_d = 1'b0;
                    state_d     = ST_XFER;
                end
            end

            ST_XFER: begin
                if (HREADY) begin
                    // The previous data phase (if any) completes on this edge.
                    if (dph_valid && !HWRITE) begin
                        rd_data_d  = HRDATA;
                        rd_valid_d = 1'b1;
                    end
                    // The current address phase moves into its data phase;
                    // for writes its word must be on HWDATA from the next cycle.
                    if (HWRITE) begin
                        hwdata_d = wr_data;
                        wr_pop_d = 1'b1;
                    end
                    dph_valid_d = 1'b1;
                    if (addr_left != '0) begin
                        htrans_d    = TR_SEQ;
                        haddr_d     = HADDR + ADDR_W'(8);
                        addr_left_d = addr_left - LEN_W'(1);
                    end else begin
                        htrans_d = TR_IDLE;
                        state_d  = ST_LAST;
                    end
                end else if (HRESP) begin
                    // First ERROR cycle: withdraw the pending address phase.
                    htrans_d = TR_IDLE;
                    state_d  = ST_ERR;
                end
            end

            ST_LAST: begin
                if (HREADY) begin
                    if (!HWRITE) begin
                        rd_data_d  = HRDATA;
                        rd_valid_d = 1'b1;
                    end
                    done_d      = 1'b1;
                    dph_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else if (HRESP) begin
                    state_d = ST_ERR;
                end
            end

            ST_ERR: begin
                // Second ERROR cycle ends the burst; the errored beat carries
                // no valid read data.
                if (HREADY) begin
                    err_d       = 1'b1;
                    dph_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state     <= ST_IDLE;
            addr_left <= '0;
            dph_valid <= 1'b0;
            HTRANS    <= TR_IDLE;
            HADDR     <= '0;
            HWRITE    <= 1'b0;
            HBURST    <= BURST_SINGLE;
            HWDATA    <= '0;
            rd_data   <= '0;
            wr_pop    <= 1'b0;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            state     <= state_d;
            addr_left <= addr_left_d;
            dph_valid <= dph_valid_d;
            HTRANS    <= htrans_d;
            HADDR     <= haddr_d;
            HWRITE    <= hwrite_d;
            HBURST    <= hburst_d;
            HWDATA    <= hwdata_d;
            rd_data   <= rd_data_d;
            wr_pop    <= wr_pop_d;
            rd_valid  <= rd_valid_d;
            done      <= done_d;
            err       <= err_d;
            cmd_ready <= cmd_ready_d;
        end
    end

endmodule

// File: tb/tb_ahb_burst_master.sv
// tb/tb_ahb_burst_master.sv - scoreboard bench for ahb_burst_master
module tb_ahb_burst_master;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic [63:0] wr_data;
    logic        wr_pop, rd_valid, done, err;
    logic [63:0] rd_data;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [63:0] HWDATA;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;
    logic [63:0] HRDATA = '0;

    always #5 HCLK = ~HCLK;

    ahb_burst_master dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_pop(wr_pop),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard queues
    logic [31:0] exp_addr[$];
    logic [63:0] exp_wd[$];
    logic [63:0] exp_rd[$];

    // Write word source: advances when wr_pop is seen
    logic [63:0] wr_words[16];
    int          widx = 0;
    assign wr_data = wr_words[widx[3:0]];

    // Slave model / monitor state
    int          cyc = 0, aidx = 0, dbeat = 0, waits_left = 0;
    int          wait_beat = -1, err_beat = -1, err_phase = 0;
    logic        dph = 1'b0, dwrite = 1'b0, p_wait = 1'b0, cur_write = 1'b0;
    logic [3:0]  cur_len = '0;
    logic [31:0] p_haddr = '0, last_haddr = '0;
    logic [1:0]  p_htrans = '0;
    logic [63:0] p_hwdata = '0, rd_base = '0;
    int          n_pop = 0, n_rv = 0, n_done = 0, n_err = 0;
    int          t_nonseq = 0, t_done = 0, t_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: sample DUT at the falling edge, score it, then drive the
    // slave response for the rising edge that follows.
    task automatic step();
        @(negedge HCLK);
        cyc++;
        if (wr_pop) begin n_pop++; widx++; end
        if (rd_valid) begin
            n_rv++;
            if (exp_rd.size() == 0) check("rd_valid_extra", rd_valid, 0);
            else check("rd_data", rd_data, exp_rd.pop_front());
        end
        if (done) begin n_done++; t_done = cyc; end
        if (err) begin n_err++; t_err = cyc; end
        check("no_busy", HTRANS == 2'b01, 0);
        if (p_wait) begin
            check("hold_haddr", HADDR, p_haddr);
            check("hold_htrans", HTRANS, p_htrans);
            check("hold_hwdata", HWDATA, p_hwdata);
            check("wait_pulses", {done, err, wr_pop, rd_valid}, 0);
        end

        HRESP = 1'b0;
        HREADY = 1'b1;
        HRDATA = 64'h5a5a_5a5a_5a5a_5a5a;
        if (err_phase == 1) begin
            check("err2_htrans", HTRANS, 2'b00);
            HRESP = 1'b1;
            err_phase = 0;
            dph = 1'b0;
        end else if (dph) begin
            if (dbeat == err_beat) begin
                HRESP = 1'b1;
                HREADY = 1'b0;
                err_phase = 1;
            end else if (dbeat == wait_beat && waits_left > 0) begin
                HREADY = 1'b0;
                waits_left--;
            end else begin
                if (dwrite) begin
                    if (exp_wd.size() == 0) check("wd_extra", exp_wd.size(), 1);
                    else check("hwdata", HWDATA, exp_wd.pop_front());
                end else begin
                    HRDATA = rd_base + 64'(dbeat);
                    exp_rd.push_back(HRDATA);
                end
                dph = 1'b0;
            end
        end

        if (HREADY && HTRANS[1]) begin
            if (exp_addr.size() == 0) check("aphase_extra", HTRANS, 0);
            else check("haddr", HADDR, exp_addr.pop_front());
            check("htrans", HTRANS, (aidx == 0) ? 2'b10 : 2'b11);
            check("hwrite", HWRITE, cur_write);
            check("hburst", HBURST, (cur_len == 0) ? 3'b000 : 3'b001);
            check("hsize_hprot_lock", {HSIZE, HPROT, HMASTLOCK}, {3'b011, 4'h3, 1'b0});
            if (aidx == 0) t_nonseq = cyc;
            last_haddr = HADDR;
            dbeat = aidx;
            aidx++;
            dph = 1'b1;
            dwrite = HWRITE;
        end
        p_wait = !HREADY && !HRESP;
        p_haddr = HADDR;
        p_htrans = HTRANS;
        p_hwdata = HWDATA;
    endtask

    // Present a command (possibly before cmd_ready) and return on the NONSEQ cycle.
    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] l);
        logic acc;
        int   g;
        acc = 1'b0;
        g = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr = a;
        cmd_len = l;
        for (int i = 0; i <= int'(l); i++) begin
            exp_addr.push_back(a + 32'(8 * i));
            if (w) exp_wd.push_back(wr_words[i]);
        end
        cur_write = w;
        cur_len = l;
        aidx = 0;
        widx = 0;
        while (!acc && g < 50) begin
            acc = cmd_ready;
            step();
            g++;
        end
        cmd_valid = 1'b0;
        check("cmd_accept", acc, 1);
    endtask

    task automatic wait_end();
        int d0, e0, g;
        d0 = n_done;
        e0 = n_err;
        g = 0;
        while (n_done == d0 && n_err == e0 && g < 200) begin
            step();
            g++;
        end
        check("burst_end_seen", (n_done != d0) || (n_err != e0), 1);
    endtask

    task automatic chk_reset(input string t);
        check({t, "_htrans"}, HTRANS, 2'b00);
        check({t, "_haddr"}, HADDR, 0);
        check({t, "_hwdata"}, HWDATA, 0);
        check({t, "_rd_data"}, rd_data, 0);
        check({t, "_hwrite"}, HWRITE, 0);
        check({t, "_hsize"}, HSIZE, 3'b011);
        check({t, "_hburst"}, HBURST, 3'b000);
        check({t, "_hprot"}, HPROT, 4'h3);
        check({t, "_hmastlock"}, HMASTLOCK, 0);
        check({t, "_pulses"}, {wr_pop, rd_valid, done, err}, 0);
        check({t, "_cmd_ready"}, cmd_ready, 1);
    endtask

    initial begin
        int p0, r0, d0, e0, dcyc, g;
        for (int i = 0; i < 16; i++) wr_words[i] = '0;

        repeat (3) step();
        chk_reset("rst");
        HRESET = 1'b1;
        step();

        // Single write
        wr_words[0] = 64'hDEAD_BEEF_0123_4567;
        p0 = n_pop;
        issue(1'b1, 32'h100, 4'd0);
        step();
        check("t1_idle_after_nonseq", HTRANS, 2'b00);
        wait_end();
        check("t1_latency", t_done - t_nonseq, 2);
        check("t1_pops", n_pop - p0, 1);
        check("t1_wd_left", exp_wd.size(), 0);

        // 4-beat read, zero wait
        rd_base = 64'd0;
        r0 = n_rv;
        issue(1'b0, 32'h200, 4'd3);
        wait_end();
        check("t2_latency", t_done - t_nonseq, 5);
        check("t2_rd_beats", n_rv - r0, 4);
        check("t2_ready_at_done", cmd_ready, 0);
        step();
        check("t2_ready_after", cmd_ready, 1);
        check("t2_rd_left", exp_rd.size(), 0);

        // 4-beat write, 2 wait states on beat 2
        for (int i = 0; i < 4; i++) wr_words[i] = {32'hC0DE_0000, 32'(i + 1)};
        wait_beat = 1;
        waits_left = 2;
        p0 = n_pop;
        issue(1'b1, 32'h240, 4'd3);
        wait_end();
        check("t3_latency", t_done - t_nonseq, 7);
        check("t3_pops", n_pop - p0, 4);
        check("t3_wd_left", exp_wd.size(), 0);
        wait_beat = -1;
        step();

        // ERROR on beat 2 of a 4-beat read
        err_beat = 1;
        rd_base = 64'h100;
        r0 = n_rv;
        d0 = n_done;
        e0 = n_err;
        issue(1'b0, 32'h300, 4'd3);
        wait_end();
        check("t4_err_count", n_err - e0, 1);
        check("t4_no_done", n_done - d0, 0);
        check("t4_rd_beats", n_rv - r0, 1);
        check("t4_err_latency", t_err - t_nonseq, 4);
        check("t4_addr_dropped", exp_addr.size(), 2);
        check("t4_rd_left", exp_rd.size(), 0);
        check("t4_ready_at_err", cmd_ready, 0);
        step();
        check("t4_ready_after", cmd_ready, 1);
        exp_addr.delete();
        err_beat = -1;

        // Reset during beat 3 of an 8-beat write
        for (int i = 0; i < 8; i++) wr_words[i] = {32'h5EED_0000, 32'(i)};
        d0 = n_done;
        e0 = n_err;
        issue(1'b1, 32'h400, 4'd7);
        g = 0;
        while (aidx < 3 && g < 20) begin step(); g++; end
        check("t5_reached_beat3", aidx, 3);
        #2;
        HRESET = 1'b0;
        dph = 1'b0;
        err_phase = 0;
        exp_addr.delete();
        exp_wd.delete();
        exp_rd.delete();
        #1;
        chk_reset("t5_rst");
        step();
        step();
        check("t5_no_end_pulse", {n_done - d0, n_err - e0}, 0);
        HRESET = 1'b1;
        step();
        wr_words[0] = 64'h1111_2222_3333_4444;
        wr_words[1] = 64'h5555_6666_7777_8888;
        p0 = n_pop;
        issue(1'b1, 32'h500, 4'd1);
        wait_end();
        check("t5_new_latency", t_done - t_nonseq, 3);
        check("t5_new_pops", n_pop - p0, 2);
        check("t5_wd_left", exp_wd.size(), 0);
        step();

        // Back-to-back: read len=0, then write len=1 presented on the done cycle
        rd_base = 64'h55;
        issue(1'b0, 32'h600, 4'd0);
        wait_end();
        dcyc = t_done;
        wr_words[0] = 64'hAAAA_0000_0000_0001;
        wr_words[1] = 64'hAAAA_0000_0000_0002;
        p0 = n_pop;
        issue(1'b1, 32'h700, 4'd1);
        check("t6_b2b_gap", t_nonseq - dcyc, 2);
        wait_end();
        check("t6_latency", t_done - t_nonseq, 3);
        check("t6_pops", n_pop - p0, 2);
        step();

        // Maximum length read
        rd_base = 64'h1000;
        r0 = n_rv;
        issue(1'b0, 32'h800, 4'd15);
        wait_end();
        check("t7_latency", t_done - t_nonseq, 17);
        check("t7_rd_beats", n_rv - r0, 16);
        check("t7_last_haddr", last_haddr, 32'h878);
        check("t7_addr_left", exp_addr.size(), 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
